// File: rtl/dds_spi_pkg.sv
// Shared definitions for the AD9951 serial-port read and write paths:
// controller state encoding, instruction-byte layout and its builder.
package dds_spi_pkg;

   localparam logic DDS_READ_FLAG = 1'b1;
   localparam int   DDS_ADDR_W    = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALIGN  = 3'd1,
      INSTR  = 3'd2,
      DATA   = 3'd3,
      STOP   = 3'd4,
      FINISH = 3'd5
   } dds_state_e;

   // Instruction byte: R/W flag, two reserved zero bits, register address.
   function automatic logic [7:0] dds_instr(input logic rw, input logic [DDS_ADDR_W-1:0] addr);
      return {rw, 2'b00, addr};
   endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Free-running 2-bit divider giving the SPI clock phase and the cycle
// before each rsclk rising/falling edge, shared by both DDS directions.
module spi_clk_tick (
   input  logic clk,
   input  logic reset,
   output logic sclk_phase_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   logic [1:0] div_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= 2'd0;
      end else begin
         div_q <= div_q + 2'd1;
      end
   end

   assign sclk_phase_o = div_q[1];
   assign rise_tick_o  = (div_q == 2'd1);
   assign fall_tick_o  = (div_q == 2'd3);

endmodule

// File: rtl/dds_register_reader.sv
// AD9951 register read-back: sends a read instruction, releases SDIO and
// shifts in 1..MAXLENGTH bytes MSB-first, returned right-aligned.
module dds_register_reader
   import dds_spi_pkg::*;
#(
   parameter int LENGTH_BIT_COUNT = 3,
   parameter int MAXLENGTH        = 7,
   parameter int MAXLENGTH8       = MAXLENGTH * 8
) (
   input  logic                        clk50MHz,
   input  logic                        reset,
   input  logic                        Read_Start,
   input  logic [DDS_ADDR_W-1:0]       Read_Addr,
   input  logic [LENGTH_BIT_COUNT-1:0] Read_Bytes,
   output logic                        Read_Busy,
   output logic [MAXLENGTH8-1:0]       Read_Data,
   output logic                        Read_Data_Valid,
   output logic                        rsclk,
   output logic                        rcsbar,
   output logic                        rsdio_out,
   output logic                        rsdio_oe,
   input  logic                        rsdio_in
);

   localparam int CNT_W = LENGTH_BIT_COUNT + 3;

   logic sclk_phase, rise_tick, fall_tick;

   spi_clk_tick u_tick (
      .clk          (clk50MHz),
      .reset        (reset),
      .sclk_phase_o (sclk_phase),
      .rise_tick_o  (rise_tick),
      .fall_tick_o  (fall_tick)
   );

   dds_state_e                  state_q;
   logic [7:0]                  instr_q;
   logic [LENGTH_BIT_COUNT-1:0] bytes_m1_q;
   logic [CNT_W-1:0]            bitcnt_q;
   logic [MAXLENGTH8-1:0]       shreg_q;
   logic [MAXLENGTH8-1:0]       data_q;
   logic                        rcsbar_q, sdio_out_q, sdio_oe_q, busy_q, valid_q;

   always_ff @(posedge clk50MHz) begin
      if (reset) begin
         state_q    <= IDLE;
         instr_q    <= 8'd0;
         bytes_m1_q <= '0;
         bitcnt_q   <= '0;
         shreg_q    <= '0;
         data_q     <= '0;
         rcsbar_q   <= 1'b1;
         sdio_out_q <= 1'b0;
         sdio_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (Read_Start) begin
                  busy_q     <= 1'b1;
                  instr_q    <= dds_instr(DDS_READ_FLAG, Read_Addr);
                  bytes_m1_q <= Read_Bytes - LENGTH_BIT_COUNT'(1);
                  shreg_q    <= '0;
                  state_q    <= (Read_Bytes == '0) ? FINISH : ALIGN;
               end
            end
            // Select and first bit change together with rsclk low, so the
            // first rising edge lands two cycles after rcsbar falls.
            ALIGN: begin
               if (fall_tick) begin
                  rcsbar_q   <= 1'b0;
                  sdio_oe_q  <= 1'b1;
                  sdio_out_q <= instr_q[7];
                  bitcnt_q   <= CNT_W'(7);
                  state_q    <= INSTR;
               end
            end
            INSTR: begin
               if (fall_tick) begin
                  if (bitcnt_q != '0) begin
                     sdio_out_q <= instr_q[6];
                     instr_q    <= {instr_q[6:0], 1'b0};
                     bitcnt_q   <= bitcnt_q - CNT_W'(1);
                  end else begin
                     // 8*bytes-1 without a multiplier: {bytes-1, 3'b111}
                     sdio_oe_q <= 1'b0;
                     bitcnt_q  <= {bytes_m1_q, 3'b111};
                     state_q   <= DATA;
                  end
               end
            end
            DATA: begin
               if (rise_tick) begin
                  shreg_q <= {shreg_q[MAXLENGTH8-2:0], rsdio_in};
                  if (bitcnt_q == '0) begin
                     state_q <= STOP;
                  end else begin
                     bitcnt_q <= bitcnt_q - CNT_W'(1);
                  end
               end
            end
            STOP: begin
               if (fall_tick) begin
                  rcsbar_q <= 1'b1;
                  state_q  <= FINISH;
               end
            end
            FINISH: begin
               data_q  <= shreg_q;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Select only toggles on the edge where the divider returns to 0,
   // i.e. while the phase bit is low, so the gated clock cannot glitch.
   assign rsclk           = sclk_phase & ~rcsbar_q;
   assign rcsbar          = rcsbar_q;
   assign rsdio_out       = sdio_out_q;
   assign rsdio_oe        = sdio_oe_q;
   assign Read_Busy       = busy_q;
   assign Read_Data       = data_q;
   assign Read_Data_Valid = valid_q;

endmodule

// File: doc/dds_register_reader.md
Name: dds_register_reader

Overview:
- Reads AD9951 DDS registers back over the serial port. It is the read-side counterpart of the DDS write path.
- Issues an 8-bit read instruction (R/W bit = 1, 5-bit address), releases SDIO, then shifts in 1..MAXLENGTH bytes MSB-first.
- Returns the bytes right-aligned in the same format the write path accepts as DDS_Data, so the host can verify what was written.
- Sits beside the DDS write controller on the same DDS chip; one instance per DDS chip.

Parameters:
- LENGTH_BIT_COUNT, 3, width of the byte-count input.
- MAXLENGTH, 7, maximum data bytes per read (≤ 2^LENGTH_BIT_COUNT-1).
- MAXLENGTH8, MAXLENGTH*8, width of the read-data bus.

Ports:
- clk50MHz  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- Read_Start  in  1  request strobe; sampled only in IDLE.
- Read_Addr  in  5  DDS register address.
- Read_Bytes  in  LENGTH_BIT_COUNT  number of data bytes to read.
- Read_Busy  out  1  high from the accepted request through FINISH.
- Read_Data  out  MAXLENGTH8  right-aligned result; upper unused bytes are 0.
- Read_Data_Valid  out  1  one-cycle pulse when Read_Data is updated.
- rsclk  out  1  SPI clock to the DDS.
- rcsbar  out  1  chip select, active low.
- rsdio_out  out  1  serial data driven to the DDS.
- rsdio_oe  out  1  tristate enable for the SDIO pad.
- rsdio_in  in  1  serial data from the DDS pad.

Behaviour:
- Reset values: rcsbar=1, rsclk=0, rsdio_out=0, rsdio_oe=0, Read_Busy=0, Read_Data=0, Read_Data_Valid=0, div=0, state=IDLE.
- Reset asserted mid-transaction aborts immediately to these values. No partial data is delivered.
- Clock divider: 2-bit counter div, free-running, increments every clk50MHz cycle.
  - fall_tick = (div==3). On the next edge rsclk falls.
  - rise_tick = (div==1). On the next edge rsclk rises.
  - rsclk = div[1] while rcsbar=0, else 0. Period is 80 ns (12.5 MHz, below the AD9951 25 MHz limit).
  - Gating changes only when div[1]=0, so rsclk never glitches.
- IDLE:
  - Read_Busy=0.
  - On Read_Start=1: latch addr and bytes, set Read_Busy=1 on the next edge, build instr = {1'b1, 2'b00, Read_Addr}.
  - If Read_Bytes==0: go to FINISH directly with result 0. No bus activity.
  - Otherwise go to ALIGN.
- ALIGN:
  - Wait for fall_tick.
  - At that edge: rcsbar←0, rsdio_oe←1, rsdio_out←instr[7], bitcnt←7. Go to INSTR.
- INSTR:
  - On each fall_tick, if bitcnt≠0: shift out the next instruction bit, bitcnt−1.
  - On the fall_tick after the 8th rising edge: rsdio_oe←0, bitcnt←8*bytes−1. Go to DATA.
- DATA:
  - On each rise_tick: shreg ← {shreg[MAXLENGTH8-2:0], rsdio_in}. This samples about 2 cycles after the DDS falling-edge update.
  - After the last sample (bitcnt==0 at rise_tick), go to STOP.
  - Otherwise decrement bitcnt at that rise_tick.
- STOP:
  - At the next fall_tick: rcsbar←1. Go to FINISH.
- FINISH:
  - Read_Data←shreg, Read_Data_Valid←1 for one cycle, Read_Busy←0. Go to IDLE.
  - shreg is zeroed when the transaction starts, so upper bytes read 0.
- Timing: rcsbar is low for exactly (8+8N)*4 cycles. The first rsclk rising edge is 2 cycles after rcsbar falls.
- Latency, Read_Start to Read_Data_Valid: ≤ 1 + 4 (align) + (8+8N)*4 + 2 cycles.
- Read_Start while busy is ignored; it is not queued.
- Inputs are latched at acceptance. Changes during a transaction have no effect.
- Read_Data holds its value until the next valid pulse.

Decomposition:
- Package dds_spi_pkg holds:
  - state encodings IDLE/ALIGN/INSTR/DATA/STOP/FINISH (3-bit);
  - DDS_READ_FLAG=1'b1 and DDS_ADDR_W=5;
  - the instruction-byte builder function.
- The write path imports the same package.
- One natural sub-module: spi_clk_tick.
  - Contents: the 2-bit divider producing div[1], rise_tick and fall_tick.
  - Shared so both DDS directions run the same SPI timing.

Test Plan:
- Read_Addr=0x04, Read_Bytes=4; DDS model returns 0x12345678 → instruction bits 1000_0100 on rsdio_out while oe=1; rcsbar low for 160 cycles; Read_Data=0x00000012345678; one valid pulse.
- Read_Bytes=7; model returns 0xA1B2C3D4E5F607 → Read_Data=0xA1B2C3D4E5F607; rcsbar low for 256 cycles; rsclk shows exactly 64 rising edges.
- Read_Bytes=0 → no rcsbar activity; Read_Data=0; valid pulse within 3 cycles of Read_Start.
- Second Read_Start pulsed mid-DATA → ignored; exactly one valid pulse; Read_Busy stays high until FINISH.
- reset asserted during DATA → next cycle rcsbar=1, rsdio_oe=0, Read_Busy=0, Read_Data=0; no valid pulse; a following read of 2 bytes (0xBEEF) completes normally.
- Checker runs in all tests:
  - rsdio_oe is 0 on every rise_tick in DATA;
  - rsclk has no edge while rcsbar=1;
  - rsdio_out is stable across every rsclk rising edge in INSTR.
